// File: rtl/stack_sequencer.sv
// stack_sequencer: fetches 8-bit instructions, drives an external stack
// with push/pop strobes and evaluates ADD/SUB/MUL/JMP/JZ/POP/HALT.
module stack_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [4:0]       imem_addr,
  input  logic [7:0]       imem_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             halted,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_TAKE_A,
    S_TAKE_B,
    S_WRITE,
    S_HALT,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_JMP  = 3'd4,
    OP_JZ   = 3'd5,
    OP_POP  = 3'd6,
    OP_HALT = 3'd7
  } op_t;

  state_t           state;
  logic [4:0]       pc;
  logic [7:0]       ir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  op_t              op;
  logic [4:0]       operand;
  logic [WIDTH-1:0] imm;
  logic             is_binop;
  logic [WIDTH-1:0] alu_r;

  assign op        = op_t'(ir[7:5]);
  assign operand   = ir[4:0];
  assign imm       = WIDTH'(ir[4:0]);
  assign is_binop  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  assign imem_addr = pc;

  // ALU on the two popped operands: b is the deeper entry, a the top.
  always_comb begin
    alu_r = '0;
    case (op)
      OP_ADD:  alu_r = b + a;
      OP_SUB:  alu_r = b - a;
      OP_MUL:  alu_r = b * a;
      default: alu_r = '0;
    endcase
  end

  // Stack strobes and push data, decoded from state, ir and stack status.
  always_comb begin
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;
    case (state)
      S_EXEC: begin
        if (op == OP_PUSH) begin
          if (!stk_full) begin
            stk_push    = 1'b1;
            stk_data_in = imm;
          end
        end else if (op != OP_JMP && op != OP_HALT) begin
          stk_pop = !stk_empty;
        end
      end
      S_TAKE_A: begin
        if (is_binop) begin
          stk_pop = !stk_empty;
        end
      end
      S_WRITE: begin
        if (!stk_full) begin
          stk_push    = 1'b1;
          stk_data_in = alu_r;
        end
      end
      default: begin
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
      end
    endcase
  end

  // Sequencer FSM with registered status/result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      halted       <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (start) begin
            pc     <= '0;
            state  <= S_FETCH;
            halted <= 1'b0;
            error  <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= imem_data;
          pc    <= pc + 5'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_PUSH: begin
              if (stk_full) begin
                state <= S_ERR;
                error <= 1'b1;
              end else begin
                state <= S_FETCH;
              end
            end
            OP_JMP: begin
              pc    <= operand;
              state <= S_FETCH;
            end
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              if (stk_empty) begin
                state <= S_ERR;
                error <= 1'b1;
              end else begin
                state <= S_TAKE_A;
              end
            end
          endcase
        end
        S_TAKE_A: begin
          a <= stk_data_out;
          case (op)
            OP_POP: begin
              result       <= stk_data_out;
              result_valid <= 1'b1;
              state        <= S_FETCH;
            end
            OP_JZ: begin
              if (stk_data_out == '0) begin
                pc <= operand;
              end
              state <= S_FETCH;
            end
            default: begin
              if (stk_empty) begin
                state <= S_ERR;
                error <= 1'b1;
              end else begin
                state <= S_TAKE_B;
              end
            end
          endcase
        end
        S_TAKE_B: begin
          b     <= stk_data_out;
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (stk_full) begin
            state <= S_ERR;
            error <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: drives stack_sequencer with a ROM and stack model,
// checking it against an instruction-level reference model.
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out = 8'h00;
  logic       stk_full;
  logic       stk_empty;
  logic [7:0] result;
  logic       result_valid;
  logic       halted;
  logic       error;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] rom [32];
  logic [7:0] smem [8];
  int         scnt = 0;
  logic       sclr = 1'b0;

  logic [7:0] act_push[$];
  logic [7:0] act_res[$];
  logic [4:0] act_trace[$];
  int         act_pops;
  int         both_cnt;
  int         act_n;
  logic       act_halt;
  logic       act_err;

  int   m_stk[$];
  int   m_res[$];
  int   m_push[$];
  int   m_trace[$];
  int   m_pops;
  logic m_halt;
  logic m_err;

  stack_sequencer #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stk_push(stk_push),
    .stk_pop(stk_pop),
    .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out),
    .stk_full(stk_full),
    .stk_empty(stk_empty),
    .result(result),
    .result_valid(result_valid),
    .halted(halted),
    .error(error)
  );

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];
  assign stk_full  = (scnt == 8);
  assign stk_empty = (scnt == 0);

  // 8-entry stack with registered pop data
  always @(posedge clk) begin
    if (sclr) begin
      scnt <= 0;
    end else if (stk_push && scnt < 8) begin
      smem[scnt] <= stk_data_in;
      scnt <= scnt + 1;
    end else if (stk_pop && scnt > 0) begin
      stk_data_out <= smem[scnt-1];
      scnt <= scnt - 1;
    end
  end

  // observe strobes and results mid-cycle
  always @(negedge clk) begin
    if (stk_push) act_push.push_back(stk_data_in);
    if (stk_pop) act_pops++;
    if (stk_push && stk_pop) both_cnt++;
    if (result_valid) act_res.push_back(result);
  end

  function automatic logic [7:0] ins(input int op, input int opd);
    logic [7:0] v;
    v = {op[2:0], opd[4:0]};
    return v;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 8'hE0;
  endtask

  task automatic stack_clear();
    @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
  endtask

  task automatic clear_obs();
    act_push.delete();
    act_res.delete();
    act_trace.delete();
    act_pops = 0;
    both_cnt = 0;
  endtask

  // Instruction-level model: fetch addresses, pushes, pops, results.
  task automatic model_run();
    int pc, np, x, y, v;
    logic [7:0] w;
    int op, opd;
    m_stk.delete();
    for (int i = 0; i < scnt; i++) m_stk.push_back(int'(smem[i]));
    m_res.delete();
    m_push.delete();
    m_trace.delete();
    m_pops = 0;
    m_halt = 1'b0;
    m_err = 1'b0;
    pc = 0;
    for (int s = 0; s < 64 && !m_halt && !m_err; s++) begin
      w = rom[pc];
      op = int'(w[7:5]);
      opd = int'(w[4:0]);
      np = (pc + 1) % 32;
      m_trace.push_back(pc);
      m_trace.push_back(np);
      if (op == 0) begin
        if (m_stk.size() == 8) m_err = 1'b1;
        else begin
          m_stk.push_back(opd);
          m_push.push_back(opd);
          pc = np;
        end
      end else if (op == 4) begin
        pc = opd;
      end else if (op == 7) begin
        m_halt = 1'b1;
      end else if (m_stk.size() == 0) begin
        m_err = 1'b1;
      end else if (op == 5 || op == 6) begin
        v = m_stk.pop_back();
        m_pops++;
        m_trace.push_back(np);
        if (op == 6) begin
          m_res.push_back(v);
          pc = np;
        end else begin
          pc = (v == 0) ? opd : np;
        end
      end else begin
        x = m_stk.pop_back();
        m_pops++;
        m_trace.push_back(np);
        if (m_stk.size() == 0) m_err = 1'b1;
        else begin
          y = m_stk.pop_back();
          m_pops++;
          m_trace.push_back(np);
          m_trace.push_back(np);
          if (op == 1) v = y + x;
          else if (op == 2) v = y - x;
          else v = y * x;
          v = v & 255;
          m_stk.push_back(v);
          m_push.push_back(v);
          pc = np;
        end
      end
    end
  endtask

  task automatic exec_prog();
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    act_n = 0;
    while (!(halted || error) && act_n < 400) begin
      act_trace.push_back(imem_addr);
      @(posedge clk);
      #1;
      act_n++;
    end
    act_halt = halted;
    act_err = error;
    @(negedge clk);
    if (act_n >= 400) $display("FAIL timeout: no halt/error within 400 cycles");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({imem_addr, stk_push, stk_pop, stk_data_in, result,
         result_valid, halted, error} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%0h push=%b pop=%b din=%0h res=%0h rv=%b h=%b e=%b, want all 0",
               imem_addr, stk_push, stk_pop, stk_data_in, result,
               result_valid, halted, error);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({halted, error, stk_push, stk_pop} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_wait: h=%b e=%b push=%b pop=%b, want 0",
               halted, error, stk_push, stk_pop);
    end
  endtask

  task automatic test_add_program();
    clear_rom();
    stack_clear();
    rom[0] = ins(0, 3);
    rom[1] = ins(0, 4);
    rom[2] = ins(1, 0);
    rom[3] = ins(6, 0);
    rom[4] = ins(7, 0);
    model_run();
    exec_prog();
    n_checks++;
    if (act_res.size() != 1 || act_res[0] !== 8'd7) begin
      n_fail++;
      $display("FAIL add_result: got %0d pulses first=%0h, want 1 pulse 07",
               act_res.size(), act_res.size() ? act_res[0] : 8'hxx);
    end
    n_checks++;
    if (act_n != m_trace.size() || act_halt !== 1'b1) begin
      n_fail++;
      $display("FAIL add_halt_time: got %0d cycles halted=%b, want %0d halted=1",
               act_n, act_halt, m_trace.size());
    end
    n_checks++;
    if (scnt != 0) begin
      n_fail++;
      $display("FAIL add_stack_empty: got depth %0d, want 0", scnt);
    end
  endtask

  task automatic test_sub_mul();
    int want [2];
    int opc [2];
    int va [2];
    int vb [2];
    want[0] = 'hFD; opc[0] = 2; vb[0] = 2;  va[0] = 5;
    want[1] = 'h90; opc[1] = 3; vb[1] = 20; va[1] = 20;
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      stack_clear();
      rom[0] = ins(0, vb[k]);
      rom[1] = ins(0, va[k]);
      rom[2] = ins(opc[k], 0);
      rom[3] = ins(6, 0);
      rom[4] = ins(7, 0);
      exec_prog();
      n_checks++;
      if (act_res.size() != 1 || int'(act_res[0]) != want[k]) begin
        n_fail++;
        $display("FAIL arith_op%0d: got %0d pulses first=%0h, want %0h",
                 opc[k], act_res.size(),
                 act_res.size() ? act_res[0] : 8'hxx, want[k]);
      end
    end
  endtask

  task automatic test_jz();
    int want_fetch [5];
    int fi;
    int bad;
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      stack_clear();
      rom[0] = ins(0, k);
      rom[1] = ins(5, 3);
      rom[2] = ins(7, 0);
      rom[3] = ins(0, 9);
      rom[4] = ins(6, 0);
      rom[5] = ins(7, 0);
      model_run();
      exec_prog();
      bad = 0;
      if (act_trace.size() != m_trace.size()) bad = 1;
      else
        for (int i = 0; i < m_trace.size(); i++)
          if (int'(act_trace[i]) != m_trace[i]) bad = 1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL jz%0d_addr_trace: got %p, want %p", k, act_trace, m_trace);
      end
      if (k == 0) begin
        want_fetch = '{0, 1, 3, 4, 5};
        fi = 0;
        bad = 0;
        // fetch cycles: 2,3,2,3,2 cycles long
        foreach (want_fetch[i]) begin
          if (fi >= act_trace.size() || int'(act_trace[fi]) != want_fetch[i]) bad = 1;
          fi += (i == 1 || i == 3) ? 3 : 2;
        end
        n_checks++;
        if (bad || act_res.size() != 1 || act_res[0] !== 8'd9) begin
          n_fail++;
          $display("FAIL jz_taken: trace %p res %p, want fetch 0,1,3,4,5 res 9",
                   act_trace, act_res);
        end
      end else begin
        n_checks++;
        if (act_res.size() != 0 || act_halt !== 1'b1 || imem_addr !== 5'd3) begin
          n_fail++;
          $display("FAIL jz_not_taken: pulses %0d halted %b addr %0d, want 0 1 3",
                   act_res.size(), act_halt, imem_addr);
        end
      end
    end
  endtask

  task automatic test_underflow();
    clear_rom();
    stack_clear();
    rom[0] = ins(0, 1);
    rom[1] = ins(1, 0);
    exec_prog();
    repeat (3) @(negedge clk);
    n_checks++;
    if (act_pops != 1 || act_err !== 1'b1 || error !== 1'b1 ||
        act_push.size() != 1) begin
      n_fail++;
      $display("FAIL underflow: pops %0d err %b pushes %0d, want 1 1 1",
               act_pops, act_err, act_push.size());
    end
  endtask

  task automatic test_overflow();
    clear_rom();
    stack_clear();
    for (int i = 0; i < 9; i++) rom[i] = ins(0, i + 1);
    model_run();
    exec_prog();
    n_checks++;
    if (act_push.size() != 8 || act_err !== 1'b1 || scnt != 8 ||
        act_n != m_trace.size()) begin
      n_fail++;
      $display("FAIL overflow: pushes %0d err %b depth %0d cycles %0d, want 8 1 8 %0d",
               act_push.size(), act_err, scnt, act_n, m_trace.size());
    end
  endtask

  task automatic test_reset_mid_add();
    clear_rom();
    stack_clear();
    rom[0] = ins(0, 3);
    rom[1] = ins(0, 4);
    rom[2] = ins(1, 0);
    rom[3] = ins(6, 0);
    rom[4] = ins(7, 0);
    exec_prog();
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({imem_addr, stk_push, stk_pop, stk_data_in, result,
         result_valid, halted, error} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_mid_add_outputs: addr=%0h push=%b pop=%b din=%0h res=%0h rv=%b h=%b e=%b, want all 0",
               imem_addr, stk_push, stk_pop, stk_data_in, result,
               result_valid, halted, error);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (act_push.size() != 2 || act_pops != 2) begin
      n_fail++;
      $display("FAIL reset_mid_add_strobes: pushes %0d pops %0d, want 2 2",
               act_push.size(), act_pops);
    end
    exec_prog();
    n_checks++;
    if (act_trace.size() == 0 || act_trace[0] !== 5'd0 ||
        act_res.size() != 1 || act_res[0] !== 8'd7) begin
      n_fail++;
      $display("FAIL reset_restart: trace %p res %p, want start at 0 res 7",
               act_trace, act_res);
    end
  endtask

  task automatic test_random();
    int r;
    int bad;
    for (int t = 0; t < 25; t++) begin
      if (t % 5 == 0) stack_clear();
      clear_rom();
      for (int p = 0; p < 31; p++) begin
        r = $urandom_range(0, 11);
        if (r < 5) rom[p] = ins(0, $urandom_range(0, 31));
        else if (r < 8) rom[p] = ins(r - 4, 0);
        else if (r == 8) rom[p] = ins(4, $urandom_range(31, p + 1));
        else if (r == 9) rom[p] = ins(5, $urandom_range(31, p + 1));
        else if (r == 10) rom[p] = ins(6, 0);
        else rom[p] = ($urandom_range(0, 3) == 0) ? ins(7, 0) : ins(6, 0);
      end
      model_run();
      exec_prog();
      n_checks++;
      if (act_halt !== m_halt || act_err !== m_err || act_n != m_trace.size()) begin
        n_fail++;
        $display("FAIL rand%0d_outcome: h=%b e=%b cyc=%0d, want h=%b e=%b cyc=%0d",
                 t, act_halt, act_err, act_n, m_halt, m_err, m_trace.size());
      end
      bad = (act_trace.size() != m_trace.size());
      if (!bad)
        foreach (m_trace[i]) if (int'(act_trace[i]) != m_trace[i]) bad = 1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand%0d_trace: got %0d entries, want %0d", t,
                 act_trace.size(), m_trace.size());
      end
      bad = (act_push.size() != m_push.size());
      if (!bad)
        foreach (m_push[i]) if (int'(act_push[i]) != m_push[i]) bad = 1;
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand%0d_pushes: got %p, want %p", t, act_push, m_push);
      end
      bad = (act_res.size() != m_res.size());
      if (!bad)
        foreach (m_res[i]) if (int'(act_res[i]) != m_res[i]) bad = 1;
      n_checks++;
      if (bad || act_pops != m_pops) begin
        n_fail++;
        $display("FAIL rand%0d_results: got %p pops %0d, want %p pops %0d",
                 t, act_res, act_pops, m_res, m_pops);
      end
      bad = (scnt != m_stk.size());
      if (!bad)
        foreach (m_stk[i]) if (int'(smem[i]) != m_stk[i]) bad = 1;
      n_checks++;
      if (bad || both_cnt != 0) begin
        n_fail++;
        $display("FAIL rand%0d_stack: depth %0d both %0d, want depth %0d both 0",
                 t, scnt, both_cnt, m_stk.size());
      end
    end
  endtask

  initial begin
    clear_rom();
    clear_obs();
    test_reset();
    test_add_program();
    test_sub_mul();
    test_jz();
    test_underflow();
    test_overflow();
    test_reset_mid_add();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
